// File: rtl/hit_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// hit_buffer_ctrl
//
// Read-side controller for a 512-entry circular hit buffer. The buffer is
// written every bunch crossing at wrAddr. When a level-1 accept arrives, this
// block works out which buffer slot holds the triggered crossing (wrAddr minus
// the trigger latency) and queues that address. A small FSM pulls addresses
// from the queue and produces one read per trigger: rden for one cycle with
// rdAddr valid, then hitValid for one cycle while the buffer output is valid.
//
// Parameters
//   QDEPTH    pending-trigger queue depth (power of 2, 2..8)
//
// Ports
//   clk       in   40 MHz bunch-crossing clock, rising edge
//   rstn      in   asynchronous active-low reset
//   enable    in   write pointer advances when high
//   L1A       in   level-1 accept, one-cycle pulse per trigger
//   latency   in   [8:0] trigger latency in clock cycles (2..511)
//   wrAddr    out  [8:0] circular-buffer write address
//   rdAddr    out  [8:0] circular-buffer read address (held between reads)
//   rden      out  read enable, one cycle per trigger
//   hitValid  out  buffer output valid, the cycle after rden
//   qCount    out  [3:0] triggers queued and not yet read
//   ovfCount  out  [7:0] dropped triggers, saturating at 255
//   latErr    out  sticky: an accepted trigger had latency below 2
// ---------------------------------------------------------------------------
module hit_buffer_ctrl #(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       L1A,
    input  logic [8:0] latency,
    output logic [8:0] wrAddr,
    output logic [8:0] rdAddr,
    output logic       rden,
    output logic       hitValid,
    output logic [3:0] qCount,
    output logic [7:0] ovfCount,
    output logic       latErr
);

    localparam int         PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [3:0] QDEPTH_C = 4'(QDEPTH);
    localparam logic [8:0] MIN_LAT  = 9'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       wr_addr_q, wr_addr_d;
    logic [8:0]       rd_addr_q, rd_addr_d;
    logic [3:0]       count_q, count_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             lat_err_q, lat_err_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [8:0]       tag_mem [QDEPTH];

    logic             pop;
    logic             push;
    logic             drop;
    logic             lat_low;
    logic [8:0]       lat_eff;
    logic [8:0]       new_tag;

    // -----------------------------------------------------------------------
    // Trigger address computation
    // -----------------------------------------------------------------------
    // Latencies of 0 or 1 would point at (or past) the slot being written
    // this cycle, so they are clamped to the minimum usable latency.
    assign lat_low = (latency < MIN_LAT);
    assign lat_eff = lat_low ? MIN_LAT : latency;
    // 9-bit subtraction wraps naturally modulo 512.
    assign new_tag = wr_addr_q - lat_eff;

    // -----------------------------------------------------------------------
    // Queue push / pop decisions
    // -----------------------------------------------------------------------
    // The FSM pops whenever it is ready to start a read and something is
    // queued. The count seen here is the registered one, so a trigger pushed
    // this cycle is only visible to the FSM next cycle.
    assign pop  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (count_q != 4'd0);

    // A full queue still accepts a trigger if a slot frees up in the same
    // cycle.
    assign push = L1A && ((count_q < QDEPTH_C) || pop);
    assign drop = L1A && !push;

    // -----------------------------------------------------------------------
    // Queue storage: one register per entry, written only at the tail.
    // Contents need no reset; the pointers and count define what is valid.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_tag_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == PTR_W'(gi))) begin
                    tag_mem[gi] <= new_tag;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        wr_addr_d = wr_addr_q;
        if (enable) begin
            wr_addr_d = wr_addr_q + 9'd1;
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q + {3'b000, push} - {3'b000, pop};

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        // rdAddr is only ever loaded by a pop, so it holds between reads.
        if (pop) begin
            head_d    = head_q + PTR_W'(1);
            rd_addr_d = tag_mem[head_q];
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_comb begin
        lat_err_d = lat_err_q;
        if (push && lat_low) begin
            lat_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_addr_q <= 9'd0;
            rd_addr_q <= 9'd0;
            count_q   <= 4'd0;
            head_q    <= '0;
            tail_q    <= '0;
            ovf_q     <= 8'd0;
            lat_err_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            ovf_q     <= ovf_d;
            lat_err_q <= lat_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM: next-state logic
    // -----------------------------------------------------------------------
    // DONE goes straight back to READ when more work is queued, which gives
    // one read every two cycles under load.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != 4'd0) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (count_q != 4'd0) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read FSM: outputs (Moore, decoded straight from the state register)
    // -----------------------------------------------------------------------
    always_comb begin
        rden     = 1'b0;
        hitValid = 1'b0;
        unique case (state_q)
            ST_READ: rden     = 1'b1;
            ST_DONE: hitValid = 1'b1;
            default: begin
                rden     = 1'b0;
                hitValid = 1'b0;
            end
        endcase
    end

    assign wrAddr   = wr_addr_q;
    assign rdAddr   = rd_addr_q;
    assign qCount   = count_q;
    assign ovfCount = ovf_q;
    assign latErr   = lat_err_q;

endmodule

// File: tb/tb_hit_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hit_buffer_ctrl
//
// Directed bench for hit_buffer_ctrl (QDEPTH = 4). Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point, so every
// check sees the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_hit_buffer_ctrl;

    localparam int QD = 4;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       L1A;
    logic [8:0] latency;
    logic [8:0] wrAddr;
    logic [8:0] rdAddr;
    logic       rden;
    logic       hitValid;
    logic [3:0] qCount;
    logic [7:0] ovfCount;
    logic       latErr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Write-address model: incremented for every edge with rstn and enable high.
    int wr_model = 0;

    hit_buffer_ctrl #(.QDEPTH(QD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .L1A      (L1A),
        .latency  (latency),
        .wrAddr   (wrAddr),
        .rdAddr   (rdAddr),
        .rden     (rden),
        .hitValid (hitValid),
        .qCount   (qCount),
        .ovfCount (ovfCount),
        .latErr   (latErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic adv;
        adv = rstn && enable;
        @(posedge clk);
        #1;
        if (!rstn)    wr_model = 0;
        else if (adv) wr_model = (wr_model + 1) % 512;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wrAddr"},   32'(wrAddr),   0);
        check({tag, ".rdAddr"},   32'(rdAddr),   0);
        check({tag, ".rden"},     32'(rden),     0);
        check({tag, ".hitValid"}, 32'(hitValid), 0);
        check({tag, ".qCount"},   32'(qCount),   0);
        check({tag, ".ovfCount"}, 32'(ovfCount), 0);
        check({tag, ".latErr"},   32'(latErr),   0);
    endtask

    // Expected tags for the burst test, and read-order tracking.
    logic [8:0] burst_tag [9];
    int         rd_idx;
    int         q_exp [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 4};

    task automatic tick_watch();
        tick();
        if (rden === 1'b1) begin
            if (rd_idx < 8) check($sformatf("burst.order%0d", rd_idx), 32'(rdAddr), 32'(burst_tag[rd_idx]));
            else            check("burst.extra_read", 32'(rd_idx), 7);
            rd_idx++;
        end
    endtask

    initial begin
        logic [8:0] exp_tag;
        int         guard;

        rstn    = 1'b0;
        enable  = 1'b0;
        L1A     = 1'b0;
        latency = 9'd10;

        // ---------------- Reset state ----------------
        repeat (3) tick();
        check_all_zero("reset");

        // ---------------- wrAddr wrap over 600 cycles ----------------
        rstn   = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            check($sformatf("wrap.cyc%0d", i), 32'(wrAddr), 32'(i % 512));
        end

        // ---------------- wrAddr=100, latency=10 -> rdAddr=90 ----------------
        guard = 0;
        while (wr_model != 100 && guard < 600) begin tick(); guard++; end
        check("lat10.wrAddr", 32'(wrAddr), 100);
        L1A = 1'b1; latency = 9'd10;
        tick();
        L1A = 1'b0;
        check("lat10.q1",       32'(qCount),   1);
        check("lat10.rden_c1",  32'(rden),     0);
        tick();
        check("lat10.rden_c2",  32'(rden),     1);
        check("lat10.rdAddr",   32'(rdAddr),   90);
        check("lat10.hv_c2",    32'(hitValid), 0);
        check("lat10.q0",       32'(qCount),   0);
        tick();
        check("lat10.rden_c3",  32'(rden),     0);
        check("lat10.hv_c3",    32'(hitValid), 1);
        check("lat10.rdhold",   32'(rdAddr),   90);
        tick();
        check("lat10.hv_c4",    32'(hitValid), 0);
        check("lat10.rden_c4",  32'(rden),     0);

        // ---------------- wrAddr=5, latency=300 -> rdAddr=217 ----------------
        guard = 0;
        while (wr_model != 5 && guard < 600) begin tick(); guard++; end
        check("lat300.wrAddr", 32'(wrAddr), 5);
        L1A = 1'b1; latency = 9'd300;
        tick();
        L1A = 1'b0;
        tick();
        check("lat300.rden",   32'(rden),   1);
        check("lat300.rdAddr", 32'(rdAddr), 217);
        tick(); tick();

        // ---------------- latency 1 and 0 clamp to 2, sticky latErr ----------------
        check("laterr.init", 32'(latErr), 0);
        exp_tag = 9'(wr_model - 2);
        L1A = 1'b1; latency = 9'd1;
        tick();
        L1A = 1'b0;
        check("laterr.set1", 32'(latErr), 1);
        tick();
        check("laterr.tag1", 32'(rdAddr), 32'(exp_tag));
        tick(); tick();
        exp_tag = 9'(wr_model - 2);
        L1A = 1'b1; latency = 9'd0;
        tick();
        L1A = 1'b0;
        tick();
        check("laterr.tag0", 32'(rdAddr), 32'(exp_tag));
        tick(); tick();
        exp_tag = 9'(wr_model - 20);
        L1A = 1'b1; latency = 9'd20;
        tick();
        L1A = 1'b0;
        tick();
        check("laterr.tag20",  32'(rdAddr), 32'(exp_tag));
        check("laterr.sticky", 32'(latErr), 1);
        tick(); tick();

        // ---------------- enable=0 freezes wrAddr, reads still drain ----------------
        enable  = 1'b0;
        exp_tag = 9'(wr_model - 3);
        L1A = 1'b1; latency = 9'd3;
        tick();
        L1A = 1'b0;
        check("frozen.wr1",  32'(wrAddr), 32'(wr_model));
        tick();
        check("frozen.rden", 32'(rden),   1);
        check("frozen.tag",  32'(rdAddr), 32'(exp_tag));
        check("frozen.wr2",  32'(wrAddr), 32'(wr_model));
        tick();
        check("frozen.hv",   32'(hitValid), 1);
        tick();
        enable = 1'b1;
        tick();
        check("frozen.resume", 32'(wrAddr), 32'(wr_model));

        // ---------------- Burst of 9 consecutive L1A: one drop ----------------
        // Reads run every other cycle, so the queue gains one entry per two
        // cycles; it fills after the 7th trigger, the 8th is accepted alongside
        // a pop, and the 9th is dropped.
        rd_idx = 0;
        for (int k = 0; k < 9; k++) begin
            burst_tag[k] = 9'(wr_model - 10);
            L1A = 1'b1; latency = 9'd10;
            tick_watch();
            check($sformatf("burst.q%0d", k), 32'(qCount), 32'(q_exp[k]));
        end
        L1A = 1'b0;
        check("burst.ovf", 32'(ovfCount), 1);
        for (int k = 0; k < 30; k++) tick_watch();
        check("burst.nreads", 32'(rd_idx), 8);
        check("burst.qempty", 32'(qCount), 0);
        check("burst.ovf_hold", 32'(ovfCount), 1);

        // ---------------- ovfCount saturation ----------------
        L1A = 1'b1; latency = 9'd10;
        repeat (600) tick();
        L1A = 1'b0;
        check("sat.255", 32'(ovfCount), 255);
        repeat (20) tick();
        check("sat.hold", 32'(ovfCount), 255);
        check("sat.drained", 32'(qCount), 0);

        // ---------------- Reset in READ with qCount=3 ----------------
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_all_zero("rst1");
        for (int k = 0; k < 6; k++) begin
            L1A = 1'b1; latency = 9'd10;
            tick();
        end
        L1A = 1'b0;
        check("midread.rden", 32'(rden),   1);
        check("midread.q3",   32'(qCount), 3);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midread.async");
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("post.rden%0d", k), 32'(rden),     0);
            check($sformatf("post.hv%0d", k),   32'(hitValid), 0);
            check($sformatf("post.wr%0d", k),   32'(wrAddr),   32'(k));
        end
        check("post.q0", 32'(qCount), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
